// File: rtl/clk_div_ctrl_pkg.sv
// Shared types and constants for the clock-divider sequencer/arbiter.
// Used by clk_div_ctrl and rr_arbiter.
package clk_div_ctrl_pkg;

    // Width of a divide ratio.
    localparam int RATIO_W = 8;

    // Ratio driven after reset: 1 makes the divider bypass to the reference clock.
    localparam logic [RATIO_W-1:0] DEF_RATIO_DEFAULT = 8'd1;

    // Ratio-change sequence states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GATE   = 3'd1,
        LOAD   = 3'd2,
        SETTLE = 3'd3,
        ACK    = 3'd4
    } state_t;

endpackage

// File: rtl/clk_div_ctrl_rr_arbiter.sv
// Purely combinational round-robin arbiter.
// The grant goes to the first requesting index at or after ptr, wrapping
// around to index 0. The pointer register is owned by the caller.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       valid
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] upper_mask;
    logic [NUM_REQ-1:0] upper_req;
    logic [NUM_REQ-1:0] pick_req;

    // Mask of the indices at or above the pointer: they take priority.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
            assign upper_mask[gi] = (ID_W'(gi) >= ptr);
        end
    endgenerate

    assign upper_req = req & upper_mask;
    assign pick_req  = (|upper_req) ? upper_req : req;
    assign valid     = |req;

    // Lowest set bit of the chosen vector wins.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (pick_req[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                grant_id = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Sequencer and round-robin arbiter in front of the shared programmable
// clock divider. Each granted ratio change is applied glitch-safely:
// gate the divider, load the ratio, settle, ungate, then acknowledge.
// Optional build macro: CLK_DIV_CTRL_RANGE_CHECK_EN adds o_nack and rejects
// ratios above MAX_RATIO without touching the divider.
module clk_div_ctrl
    import clk_div_ctrl_pkg::*;
#(
    parameter int                 NUM_REQ    = 2,
    parameter int                 SETTLE_CYC = 2,
    parameter logic [RATIO_W-1:0] DEF_RATIO  = DEF_RATIO_DEFAULT
`ifdef CLK_DIV_CTRL_RANGE_CHECK_EN
    ,
    parameter logic [RATIO_W-1:0] MAX_RATIO  = 8'd128
`endif
) (
    input  logic                         i_ref_clk,
    input  logic                         i_rst,
    input  logic                         i_sys_en,
    input  logic [NUM_REQ-1:0]           i_req,
    input  logic [NUM_REQ*RATIO_W-1:0]   i_ratio,
    output logic [NUM_REQ-1:0]           o_ack,
`ifdef CLK_DIV_CTRL_RANGE_CHECK_EN
    output logic [NUM_REQ-1:0]           o_nack,
`endif
    output logic                         o_busy,
    output logic                         o_clk_en,
    output logic [RATIO_W-1:0]           o_div_ratio,
    output logic [$clog2(NUM_REQ)-1:0]   o_active_id
);

    localparam int ID_W = $clog2(NUM_REQ);

    state_t               state_reg;
    logic [3:0]           cnt_reg;
    logic [ID_W-1:0]      ptr_reg;
    logic [ID_W-1:0]      id_reg;
    logic [NUM_REQ-1:0]   grant_oh_reg;
    logic [RATIO_W-1:0]   ratio_lat_reg;
    logic [RATIO_W-1:0]   div_ratio_reg;
    logic [NUM_REQ-1:0]   ack_reg;
    logic                 busy_reg;
    logic                 clk_en_reg;
`ifdef CLK_DIV_CTRL_RANGE_CHECK_EN
    logic [NUM_REQ-1:0]   nack_reg;
`endif

    logic [NUM_REQ-1:0]   grant;
    logic [ID_W-1:0]      grant_id;
    logic                 grant_valid;
    logic [RATIO_W-1:0]   ratio_arr [NUM_REQ];
    logic [RATIO_W-1:0]   sel_ratio;
    logic                 out_of_range;
    logic [ID_W-1:0]      ptr_next;

    // Unpack the per-requester ratio fields.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ratio
            assign ratio_arr[gi] = i_ratio[gi*RATIO_W +: RATIO_W];
        end
    endgenerate

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req      (i_req),
        .ptr      (ptr_reg),
        .grant    (grant),
        .grant_id (grant_id),
        .valid    (grant_valid)
    );

    assign sel_ratio = ratio_arr[grant_id];
    assign ptr_next  = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

`ifdef CLK_DIV_CTRL_RANGE_CHECK_EN
    assign out_of_range = (sel_ratio > MAX_RATIO);
`else
    assign out_of_range = 1'b0;
`endif

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge i_ref_clk) begin
        if (i_rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            ptr_reg       <= '0;
            id_reg        <= '0;
            grant_oh_reg  <= '0;
            ratio_lat_reg <= DEF_RATIO;
            div_ratio_reg <= DEF_RATIO;
            ack_reg       <= '0;
            busy_reg      <= 1'b0;
            clk_en_reg    <= 1'b0;
`ifdef CLK_DIV_CTRL_RANGE_CHECK_EN
            nack_reg      <= '0;
`endif
        end else begin
            ack_reg <= '0;
`ifdef CLK_DIV_CTRL_RANGE_CHECK_EN
            nack_reg <= '0;
`endif
            case (state_reg)
                IDLE: begin
                    clk_en_reg <= i_sys_en;
                    if (grant_valid) begin
                        ratio_lat_reg <= sel_ratio;
                        id_reg        <= grant_id;
                        grant_oh_reg  <= grant;
                        ptr_reg       <= ptr_next;
                        busy_reg      <= 1'b1;
                        if (out_of_range) begin
                            // Rejected ratio: divider untouched, enable held.
                            state_reg  <= ACK;
                            clk_en_reg <= clk_en_reg;
`ifdef CLK_DIV_CTRL_RANGE_CHECK_EN
                            nack_reg   <= grant;
`endif
                        end else if (sel_ratio == div_ratio_reg) begin
                            // Nothing to change: acknowledge without gating.
                            state_reg <= ACK;
                            ack_reg   <= grant;
                        end else begin
                            state_reg  <= GATE;
                            clk_en_reg <= 1'b0;
                            cnt_reg    <= 4'(SETTLE_CYC - 1);
                        end
                    end
                end
                GATE: begin
                    clk_en_reg <= 1'b0;
                    if (cnt_reg == 4'd0) begin
                        state_reg <= LOAD;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                LOAD: begin
                    clk_en_reg    <= 1'b0;
                    div_ratio_reg <= ratio_lat_reg;
                    cnt_reg       <= 4'(SETTLE_CYC - 1);
                    state_reg     <= SETTLE;
                end
                SETTLE: begin
                    if (cnt_reg == 4'd0) begin
                        state_reg  <= ACK;
                        ack_reg    <= grant_oh_reg;
                        clk_en_reg <= i_sys_en;
                    end else begin
                        clk_en_reg <= 1'b0;
                        cnt_reg    <= cnt_reg - 4'd1;
                    end
                end
                ACK: begin
                    state_reg  <= IDLE;
                    busy_reg   <= 1'b0;
                    clk_en_reg <= i_sys_en;
                end
                default: begin
                    state_reg  <= IDLE;
                    busy_reg   <= 1'b0;
                    clk_en_reg <= 1'b0;
                end
            endcase
        end
    end

    assign o_ack       = ack_reg;
    assign o_busy      = busy_reg;
    assign o_clk_en    = clk_en_reg;
    assign o_div_ratio = div_ratio_reg;
    assign o_active_id = id_reg;
`ifdef CLK_DIV_CTRL_RANGE_CHECK_EN
    assign o_nack      = nack_reg;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: directed steps followed by random
// transactions, checked against a transaction-level timeline model.
// Honours CLK_DIV_CTRL_RANGE_CHECK_EN when defined.
module tb_clk_div_ctrl;

    localparam int          NR  = 3;
    localparam int          SC  = 2;
    localparam int          IDW = $clog2(NR);
    localparam logic [7:0]  DEF = 8'd1;
`ifdef CLK_DIV_CTRL_RANGE_CHECK_EN
    localparam logic [7:0]  MAXR = 8'd128;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              sys_en;
    logic [NR-1:0]     req;
    logic [NR*8-1:0]   ratio;
    logic [NR-1:0]     ack;
    logic              busy;
    logic              clk_en;
    logic [7:0]        div_ratio;
    logic [IDW-1:0]    active_id;
`ifdef CLK_DIV_CTRL_RANGE_CHECK_EN
    logic [NR-1:0]     nack;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int         m_ptr;
    logic [7:0] m_ratio;
    logic       m_en;

    clk_div_ctrl #(
        .NUM_REQ    (NR),
        .SETTLE_CYC (SC),
        .DEF_RATIO  (DEF)
    ) dut (
        .i_ref_clk   (clk),
        .i_rst       (rst),
        .i_sys_en    (sys_en),
        .i_req       (req),
        .i_ratio     (ratio),
        .o_ack       (ack),
`ifdef CLK_DIV_CTRL_RANGE_CHECK_EN
        .o_nack      (nack),
`endif
        .o_busy      (busy),
        .o_clk_en    (clk_en),
        .o_div_ratio (div_ratio),
        .o_active_id (active_id)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    // One idle cycle with no requests: enable follows sys_en.
    task automatic idle_cycle();
        @(negedge clk);
        chk("idle_clk_en", 32'(clk_en), 32'(sys_en));
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_ack", 32'(ack), 32'd0);
        chk("idle_ratio", 32'(div_ratio), 32'(m_ratio));
        m_en = sys_en;
    endtask

    // One complete transaction; called at a negedge with the DUT idle.
    // The grant happens at the next posedge. drop_at>0 drops the winner's
    // request at that cycle offset, which must not affect the outcome.
    task automatic run_txn(input int drop_at, output int w_out);
        int         w;
        int         len;
        logic [7:0] r;
        logic       rej;
        logic       changed;
        logic       exp_en;
        logic [7:0] exp_ratio;
        logic [NR-1:0] exp_ack;
        logic [NR-1:0] exp_nack;
        logic [NR-1:0] req_snap;

        req_snap = req;
        w = -1;
        for (int off = 0; off < NR; off++) begin
            if (w < 0 && req[(m_ptr + off) % NR]) w = (m_ptr + off) % NR;
        end
        w_out = w;
        if (w < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL run_txn called with no request pending");
            return;
        end
        r   = ratio[w*8 +: 8];
        rej = 1'b0;
`ifdef CLK_DIV_CTRL_RANGE_CHECK_EN
        rej = (r > MAXR);
`endif
        changed = !rej && (r != m_ratio);
        len     = changed ? 2*SC + 2 : 1;
        m_ptr   = (w + 1) % NR;

        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            if (k == len) exp_en = rej ? m_en : sys_en;
            else          exp_en = 1'b0;
            exp_ratio = (changed && k >= SC + 2) ? r : m_ratio;
            exp_ack  = '0;
            exp_nack = '0;
            if (k == len && !rej) exp_ack[w] = 1'b1;
            if (k == len && rej)  exp_nack[w] = 1'b1;
            chk("txn_clk_en", 32'(clk_en), 32'(exp_en));
            chk("txn_ratio", 32'(div_ratio), 32'(exp_ratio));
            chk("txn_ack", 32'(ack), 32'(exp_ack));
            chk("txn_busy", 32'(busy), 32'd1);
            chk("txn_active_id", 32'(active_id), 32'(w));
`ifdef CLK_DIV_CTRL_RANGE_CHECK_EN
            chk("txn_nack", 32'(nack), 32'(exp_nack));
`endif
            if (k == drop_at) req[w] = 1'b0;
        end

        if (changed) m_ratio = r;
        req[w] = 1'b0;
        @(negedge clk);
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_ack", 32'(ack), 32'd0);
        chk("post_clk_en", 32'(clk_en), 32'(sys_en));
        chk("post_ratio", 32'(div_ratio), 32'(m_ratio));
        m_en = sys_en;
        $display("txn req=%b id=%0d ratio=%0d changed=%0d rejected=%0d sys_en=%0d len=%0d",
                 req_snap, w, r, changed, rej, sys_en, len);
    endtask

    initial begin
        int w;
        int w2;
        int j;
        logic [7:0] rv;

        rst    = 1'b1;
        sys_en = 1'b1;
        req    = '0;
        ratio  = '0;
        m_ptr  = 0;
        m_ratio = DEF;
        m_en   = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_clk_en", 32'(clk_en), 32'd0);
        chk("rst_ratio", 32'(div_ratio), 32'(DEF));
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_active_id", 32'(active_id), 32'd0);
        rst = 1'b0;
        idle_cycle();
        idle_cycle();

        // Simultaneous requests 0 and 1 with pointer 0: 0 then 1
        ratio[0*8 +: 8] = 8'd4;
        ratio[1*8 +: 8] = 8'd6;
        req = 3'b011;
        run_txn(0, w);
        run_txn(0, w);

        // Latency of a changed ratio from requester 0
        ratio[0*8 +: 8] = 8'd8;
        req[0] = 1'b1;
        run_txn(0, w);

        // Same ratio again: ack at n+1, no gating
        ratio[2*8 +: 8] = 8'd8;
        req[2] = 1'b1;
        run_txn(0, w);

        // sys_en low: ratios 0 then 1, enable held low throughout
        sys_en = 1'b0;
        idle_cycle();
        ratio[1*8 +: 8] = 8'd0;
        req[1] = 1'b1;
        run_txn(0, w);
        ratio[0*8 +: 8] = 8'd1;
        req[0] = 1'b1;
        run_txn(0, w);
        sys_en = 1'b1;
        idle_cycle();

        // Winner drops its request mid-transaction
        ratio[2*8 +: 8] = 8'd37;
        req[2] = 1'b1;
        run_txn(3, w);

        // Re-request right after ack competes against a waiting requester
        ratio[0*8 +: 8] = 8'd12;
        ratio[1*8 +: 8] = 8'd13;
        req = 3'b011;
        run_txn(0, w);
        req[w] = 1'b1;
        run_txn(0, w2);
        run_txn(0, w2);

        // Reset during SETTLE aborts the transaction
        ratio[0*8 +: 8] = (m_ratio == 8'd50) ? 8'd51 : 8'd50;
        req = 3'b001;
        for (int k = 1; k <= SC + 2; k++) @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ratio", 32'(div_ratio), 32'(DEF));
        chk("abort_clk_en", 32'(clk_en), 32'd0);
        chk("abort_ack", 32'(ack), 32'd0);
        rst = 1'b0;
        m_ptr   = 0;
        m_ratio = DEF;
        for (int k = 0; k < 2*SC + 4; k++) idle_cycle();

`ifdef CLK_DIV_CTRL_RANGE_CHECK_EN
        // Out-of-range ratio is refused with nack
        ratio[0*8 +: 8] = 8'd200;
        req[0] = 1'b1;
        run_txn(0, w);
`endif

        // Random transactions
        for (int it = 0; it < 40; it++) begin
            sys_en = ($urandom_range(0, 3) != 0);
            for (j = 0; j < NR; j++) begin
                if (!req[j] && $urandom_range(0, 1) == 1) begin
                    case ($urandom_range(0, 3))
                        0:       rv = m_ratio;
                        1:       rv = 8'($urandom_range(0, 1));
                        default: rv = 8'($urandom_range(0, 255));
                    endcase
                    ratio[j*8 +: 8] = rv;
                    req[j] = 1'b1;
                end
            end
            if (req == '0) begin
                j = $urandom_range(0, NR - 1);
                ratio[j*8 +: 8] = 8'($urandom_range(0, 255));
                req[j] = 1'b1;
            end
            run_txn($urandom_range(0, 3), w);
        end
        req = '0;
        idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
